// File: rtl/intersection_scheduler_pkg.sv
// rtl/intersection_scheduler_pkg.sv - shared types and default timings for the intersection scheduler
//
// Package traffic_pkg: phase counter width, default phase durations (cycles)
// and the scheduler state encoding, which doubles as the 'phase' output.
// No ports.

package traffic_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_MIN_GREEN = 1024;
  localparam int DEF_MAX_GREEN = 2048;
  localparam int DEF_BLINK     = 128;
  localparam int DEF_YELLOW    = 512;
  localparam int DEF_ALL_RED   = 64;

  // Encodings are fixed whether or not the blink states are built, so the
  // phase output means the same thing in every configuration.
  typedef enum logic [2:0] {
    GRN_A = 3'd0,
    BLK_A = 3'd1,
    YEL_A = 3'd2,
    CLR_A = 3'd3,
    GRN_B = 3'd4,
    BLK_B = 3'd5,
    YEL_B = 3'd6,
    CLR_B = 3'd7
  } state_t;

endpackage

// File: rtl/intersection_scheduler_if.sv
// rtl/intersection_scheduler_if.sv - request and lamp bundle of the intersection scheduler
//
// Signals:
//   req_a, req_b        level requests for approach A / B
//   R_a, G_a, Y_a       lamp drives, approach A
//   R_b, G_b, Y_b       lamp drives, approach B
//   owner               right-of-way holder (0 = A, 1 = B)
//   phase[2:0]          current scheduler state encoding
// Modports: master (request source / lamp observer), slave (scheduler).

interface intersection_scheduler_if;

  logic       req_a;
  logic       req_b;
  logic       R_a;
  logic       G_a;
  logic       Y_a;
  logic       R_b;
  logic       G_b;
  logic       Y_b;
  logic       owner;
  logic [2:0] phase;

  modport master (
    output req_a, req_b,
    input  R_a, G_a, Y_a, R_b, G_b, Y_b, owner, phase
  );

  modport slave (
    input  req_a, req_b,
    output R_a, G_a, Y_a, R_b, G_b, Y_b, owner, phase
  );

endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// rtl/intersection_scheduler_phase_timer.sv - phase counter with clear, saturation and terminal compare
//
// Module phase_timer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          synchronous clear (state entry)
//   limit[W-1:0] terminal count for the current phase
//   count[W-1:0] cycles spent in the current phase
//   tc           count equals limit

module phase_timer
  import traffic_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter int SAT = DEF_MAX_GREEN - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  // Saturation keeps an indefinitely held green from wrapping back to 0,
  // which would otherwise re-arm the minimum-green comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != W'(SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - two-approach traffic light scheduler
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset (forces GRN_A)
//   bus      intersection_scheduler_if.slave: req_a/req_b in; lamps, owner, phase out
// Parameters: MIN_GREEN, MAX_GREEN, BLINK, YELLOW, ALL_RED (cycles).
// Build option: define TL_GREEN_BLINK_EN to insert the green-blink phase
// (BLK_A/BLK_B) between green and yellow; otherwise green goes to yellow.

module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int BLINK     = DEF_BLINK,
  parameter int YELLOW    = DEF_YELLOW,
  parameter int ALL_RED   = DEF_ALL_RED
) (
  input logic                    clk,
  input logic                    rst,
  intersection_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(4 * BLINK - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(ALL_RED - 1);

`ifdef TL_GREEN_BLINK_EN
  localparam state_t GRN_EXIT_A = BLK_A;
  localparam state_t GRN_EXIT_B = BLK_B;
`else
  localparam state_t GRN_EXIT_A = YEL_A;
  localparam state_t GRN_EXIT_B = YEL_B;
`endif

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;
  logic             tc;
  logic             entry;
  logic             pend_a;
  logic             pend_b;
  logic             exit_a;
  logic             exit_b;
  logic             blink_on;

  logic lamp_r_a, lamp_g_a, lamp_y_a;
  logic lamp_r_b, lamp_g_b, lamp_y_b;
  logic owner_b;

  // Any state change restarts the counter, so every phase counts from 0.
  assign entry = (state_next != state);

  phase_timer #(
    .W   (CNT_W),
    .SAT (MAX_GREEN - 1)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (entry),
    .limit (limit),
    .count (count),
    .tc    (tc)
  );

  always_comb begin
    limit = MAX_LAST;
    unique case (state)
      BLK_A, BLK_B: limit = BLK_LAST;
      YEL_A, YEL_B: limit = YEL_LAST;
      CLR_A, CLR_B: limit = CLR_LAST;
      default:      limit = MAX_LAST;
    endcase
  end

  // Green ends only when the other side is waiting: at max green, or once
  // the minimum has elapsed and the holder is no longer requesting.
  assign exit_a = pend_b && (tc || (!bus.req_a && count >= MIN_LAST));
  assign exit_b = pend_a && (tc || (!bus.req_b && count >= MIN_LAST));

`ifdef TL_GREEN_BLINK_EN
  // Blink sub-phases alternate off, on, off, on, each BLINK cycles long.
  assign blink_on = ((count / CNT_W'(BLINK)) % CNT_W'(2)) != '0;
`else
  assign blink_on = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GRN_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    lamp_r_a   = 1'b0;
    lamp_g_a   = 1'b0;
    lamp_y_a   = 1'b0;
    lamp_r_b   = 1'b0;
    lamp_g_b   = 1'b0;
    lamp_y_b   = 1'b0;
    owner_b    = 1'b0;
    unique case (state)
      GRN_A: begin
        if (exit_a) state_next = GRN_EXIT_A;
        lamp_g_a = 1'b1;
        lamp_r_b = 1'b1;
      end
      BLK_A: begin
        if (tc) state_next = YEL_A;
        lamp_g_a = blink_on;
        lamp_r_b = 1'b1;
      end
      YEL_A: begin
        if (tc) state_next = CLR_A;
        lamp_y_a = 1'b1;
        lamp_r_b = 1'b1;
      end
      CLR_A: begin
        if (tc) state_next = GRN_B;
        lamp_r_a = 1'b1;
        lamp_r_b = 1'b1;
      end
      GRN_B: begin
        if (exit_b) state_next = GRN_EXIT_B;
        lamp_r_a = 1'b1;
        lamp_g_b = 1'b1;
        owner_b  = 1'b1;
      end
      BLK_B: begin
        if (tc) state_next = YEL_B;
        lamp_r_a = 1'b1;
        lamp_g_b = blink_on;
        owner_b  = 1'b1;
      end
      YEL_B: begin
        if (tc) state_next = CLR_B;
        lamp_r_a = 1'b1;
        lamp_y_b = 1'b1;
        owner_b  = 1'b1;
      end
      CLR_B: begin
        if (tc) state_next = GRN_A;
        lamp_r_a = 1'b1;
        lamp_r_b = 1'b1;
        owner_b  = 1'b1;
      end
      default: state_next = GRN_A;
    endcase
  end

  // Pending flags remember a request made while the approach was not green;
  // entering that approach's green clears it even if requested that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      if (entry && state_next == GRN_A) begin
        pend_a <= 1'b0;
      end else if (bus.req_a && state != GRN_A) begin
        pend_a <= 1'b1;
      end
      if (entry && state_next == GRN_B) begin
        pend_b <= 1'b0;
      end else if (bus.req_b && state != GRN_B) begin
        pend_b <= 1'b1;
      end
    end
  end

  assign bus.R_a   = lamp_r_a;
  assign bus.G_a   = lamp_g_a;
  assign bus.Y_a   = lamp_y_a;
  assign bus.R_b   = lamp_r_b;
  assign bus.G_b   = lamp_g_b;
  assign bus.Y_b   = lamp_y_b;
  assign bus.owner = owner_b;
  assign bus.phase = state;

endmodule
